// File: rtl/power_ctrl_pkg.sv
// Shared encodings and default timing constants for the power/mode controller.
`timescale 1ns/1ps
package power_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON       = 2'd1,
        ST_REL_WAIT = 2'd2
    } pwr_state_e;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_SEMI   = 2'd1,
        MODE_AUTO   = 2'd2
    } drive_mode_e;

    localparam int unsigned PRESS_CYCLES_DEF = 50;
    localparam int unsigned DEB_CYCLES_DEF   = 4;
    localparam logic [31:0] IDLE_CYCLES_DEF  = 32'd100_000_000;
    localparam int unsigned IDLE_W           = 32;

    // Mode rotation manual -> semi-auto -> auto -> manual.
    function automatic drive_mode_e next_mode(input drive_mode_e m);
        case (m)
            MODE_MANUAL: return MODE_SEMI;
            MODE_SEMI:   return MODE_AUTO;
            default:     return MODE_MANUAL;
        endcase
    endfunction

endpackage

// File: rtl/power_mode_ctrl_hold_detector.sv
// hold_detector: one-cycle strobe on the Nth consecutive high cycle of level.
// The strobe is combinational so the consumer acts on the same edge the count reaches N.
`timescale 1ns/1ps
module hold_detector #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic strobe_c
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating run-length counter; a low cycle clears it and re-arms the strobe.
    always_comb begin
        cnt_d = cnt_q;
        if (!level) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(N)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_c = level && (cnt_q == CW'(N - 1));

endmodule

// File: rtl/power_mode_ctrl.sv
// Power/drive-mode controller: long press toggles power, mode button rotates drive mode.
// Optional auto power-off on inactivity is enabled with macro POWER_IDLE_TIMEOUT_EN.
`timescale 1ns/1ps
module power_mode_ctrl
    import power_ctrl_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES = PRESS_CYCLES_DEF,
    parameter int unsigned DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter logic [31:0] IDLE_CYCLES  = IDLE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_power,
    input  logic       btn_mode,
    input  logic       activity,
    output logic       power_on,
    output logic [1:0] mode,
    output logic [1:0] state,
    output logic       pwr_evt
);

    pwr_state_e  state_q, state_d;
    drive_mode_e mode_q, mode_d;
    logic        power_on_q, power_on_d;
    logic        pwr_evt_q, pwr_evt_d;
    logic        pwr_long_c;
    logic        mode_strb_c;
    logic        idle_fire_c;

    hold_detector #(.N(PRESS_CYCLES)) u_power_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .level    (btn_power),
        .strobe_c (pwr_long_c)
    );

    hold_detector #(.N(DEB_CYCLES)) u_mode_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .level    (btn_mode),
        .strobe_c (mode_strb_c)
    );

`ifdef POWER_IDLE_TIMEOUT_EN
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              busy_c;

    assign busy_c      = activity || btn_power || btn_mode;
    assign idle_fire_c = (state_q == ST_ON) && !busy_c && (idle_q == IDLE_CYCLES - 32'd1);

    // Counts quiet cycles in ON only; anything else restarts the count.
    always_comb begin
        idle_d = '0;
        if ((state_q == ST_ON) && !busy_c && !idle_fire_c) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_idle_c;

    assign idle_fire_c   = 1'b0;
    assign unused_idle_c = ^{activity, IDLE_CYCLES};
`endif

    // Next-state logic; a power long press outranks a same-edge mode event.
    always_comb begin
        state_d    = state_q;
        power_on_d = power_on_q;
        mode_d     = mode_q;
        case (state_q)
            ST_OFF: begin
                if (pwr_long_c) begin
                    power_on_d = 1'b1;
                    mode_d     = MODE_MANUAL;
                    state_d    = ST_REL_WAIT;
                end
            end
            ST_ON: begin
                if (pwr_long_c) begin
                    power_on_d = 1'b0;
                    state_d    = ST_REL_WAIT;
                end else if (idle_fire_c) begin
                    power_on_d = 1'b0;
                    state_d    = ST_OFF;
                end else if (mode_strb_c) begin
                    mode_d = next_mode(mode_q);
                end
            end
            ST_REL_WAIT: begin
                if (!btn_power) begin
                    state_d = power_on_q ? ST_ON : ST_OFF;
                end
            end
            default: begin
                state_d    = ST_OFF;
                power_on_d = 1'b0;
            end
        endcase
        pwr_evt_d = power_on_d ^ power_on_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            power_on_q <= 1'b0;
            mode_q     <= MODE_MANUAL;
            pwr_evt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            power_on_q <= power_on_d;
            mode_q     <= mode_d;
            pwr_evt_q  <= pwr_evt_d;
        end
    end

    assign power_on = power_on_q;
    assign mode     = mode_q;
    assign state    = state_q;
    assign pwr_evt  = pwr_evt_q;

endmodule

// File: tb/tb_power_mode_ctrl.sv
// Self-checking bench for power_mode_ctrl: vector table, corner sequences, random vs. reference model.
`timescale 1ns/1ps
module tb_power_mode_ctrl;

    localparam int unsigned PRESS = 50;
    localparam int unsigned DEB   = 4;
    localparam logic [31:0] IDLE  = 32'd1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_power = 1'b0;
    logic       btn_mode = 1'b0;
    logic       activity = 1'b0;
    logic       power_on;
    logic [1:0] mode;
    logic [1:0] state;
    logic       pwr_evt;

    always #5 clk = ~clk;

    power_mode_ctrl #(
        .PRESS_CYCLES (PRESS),
        .DEB_CYCLES   (DEB),
        .IDLE_CYCLES  (IDLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_power (btn_power),
        .btn_mode  (btn_mode),
        .activity  (activity),
        .power_on  (power_on),
        .mode      (mode),
        .state     (state),
        .pwr_evt   (pwr_evt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run lengths of each button plus power/mode bookkeeping.
    bit m_on, m_wait, m_evt;
    int m_mode, p_run, b_run, idle_cnt;

    typedef struct {
        bit bp;
        bit bm;
        bit act;
        int cycles;
        bit e_pwr;
        int e_mode;
        int e_state;
        bit e_evt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit bp, input bit bm, input bit act, input int cycles,
                       input bit e_pwr, input int e_mode, input int e_state, input bit e_evt);
        vec_t v;
        v.bp = bp; v.bm = bm; v.act = act; v.cycles = cycles;
        v.e_pwr = e_pwr; v.e_mode = e_mode; v.e_state = e_state; v.e_evt = e_evt;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_on = 0; m_wait = 0; m_evt = 0; m_mode = 0;
        p_run = 0; b_run = 0; idle_cnt = 0;
    endtask

    task automatic model_step(input bit bp, input bit bm, input bit act);
        bit long_p, mev, fire, prev_on;
        p_run   = bp ? p_run + 1 : 0;
        b_run   = bm ? b_run + 1 : 0;
        long_p  = (p_run == int'(PRESS));
        mev     = (b_run == int'(DEB));
        prev_on = m_on;
        fire    = 0;
`ifdef POWER_IDLE_TIMEOUT_EN
        if (m_on && !m_wait && !act && !bp && !bm) begin
            idle_cnt++;
            if (idle_cnt == int'(IDLE)) fire = 1;
        end else begin
            idle_cnt = 0;
        end
`else
        if (act) idle_cnt = 0;
`endif
        if (m_wait) begin
            if (!bp) m_wait = 0;
        end else if (!m_on) begin
            if (long_p) begin m_on = 1; m_mode = 0; m_wait = 1; end
        end else begin
            if (long_p) begin m_on = 0; m_wait = 1; end
            else if (fire) begin m_on = 0; idle_cnt = 0; end
            else if (mev) m_mode = (m_mode + 1) % 3;
        end
        m_evt = (m_on != prev_on);
    endtask

    task automatic check(input string name, input bit e_pwr, input int e_mode,
                         input int e_state, input bit e_evt);
        n_tests++;
        if (power_on !== e_pwr || int'(mode) != e_mode || int'(state) != e_state ||
            pwr_evt !== e_evt || $isunknown({power_on, mode, state, pwr_evt})) begin
            n_fail++;
            $display("FAIL %s @%0t: power_on=%0b mode=%0d state=%0d pwr_evt=%0b, expected %0b %0d %0d %0b",
                     name, $time, power_on, mode, state, pwr_evt, e_pwr, e_mode, e_state, e_evt);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_on, m_mode, m_wait ? 2 : (m_on ? 1 : 0), m_evt);
    endtask

    // One clock: drive inputs, advance model, compare after the edge.
    task automatic step(input bit bp, input bit bm, input bit act, input string name);
        btn_power = bp; btn_mode = bm; activity = act;
        model_step(bp, bm, act);
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Power-on thresholds, held button, mode rotation, ignored mode while off.
        add(1, 0, 0,  49, 0, 0, 0, 0);
        add(0, 0, 0,   1, 0, 0, 0, 0);
        add(1, 0, 0,  50, 1, 0, 2, 1);
        add(1, 0, 0, 450, 1, 0, 2, 0);
        add(0, 0, 0,   1, 1, 0, 1, 0);
        add(0, 1, 0,   6, 1, 1, 1, 0);
        add(0, 0, 0,   3, 1, 1, 1, 0);
        add(0, 1, 0,   6, 1, 2, 1, 0);
        add(0, 0, 0,   3, 1, 2, 1, 0);
        add(0, 1, 0,   6, 1, 0, 1, 0);
        add(0, 0, 0,   3, 1, 0, 1, 0);
        add(0, 1, 0,   6, 1, 1, 1, 0);
        add(0, 0, 0,   3, 1, 1, 1, 0);
        add(0, 1, 0,   3, 1, 1, 1, 0);
        add(0, 0, 0,   2, 1, 1, 1, 0);
        add(1, 0, 0,  50, 0, 1, 2, 1);
        add(0, 0, 0,   1, 0, 1, 0, 0);
        add(0, 1, 0,   6, 0, 1, 0, 0);
        add(0, 0, 0,   2, 0, 1, 0, 0);
        add(1, 0, 0,  50, 1, 0, 2, 1);
        add(0, 0, 0,   1, 1, 0, 1, 0);
`ifdef POWER_IDLE_TIMEOUT_EN
        add(0, 0, 0, 998, 1, 0, 1, 0);
        add(0, 0, 1,   1, 1, 0, 1, 0);
        add(0, 0, 0, 999, 1, 0, 1, 0);
        add(0, 0, 0,   1, 0, 0, 0, 1);
        add(0, 0, 0,   5, 0, 0, 0, 0);
`else
        add(0, 0, 0, 1200, 1, 0, 1, 0);
`endif

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++)
                step(vecs[i].bp, vecs[i].bm, vecs[i].act, "vec_cycle");
            check($sformatf("vec_row%0d", i), vecs[i].e_pwr, vecs[i].e_mode,
                  vecs[i].e_state, vecs[i].e_evt);
        end

        // Power long press and mode debounce completing on the same edge.
        if (!m_on) begin
            for (int c = 0; c < int'(PRESS); c++) step(1, 0, 1, "coll_on");
            step(0, 0, 1, "coll_on_rel");
        end
        for (int c = 0; c < int'(PRESS) - int'(DEB); c++) step(1, 0, 1, "coll_hold");
        for (int c = 0; c < int'(DEB); c++) step(1, 1, 1, "coll_both");
        check("collision", 0, 0, 2, 1);
        step(0, 0, 1, "coll_rel");
        check("collision_rel", 0, 0, 0, 0);

        // Randomised button segments against the model.
        for (int s = 0; s < 300; s++) begin
            bit bp, bm;
            int len;
            bp  = ($urandom_range(0, 9) < 3);
            bm  = ($urandom_range(0, 9) < 4);
            len = bp ? int'($urandom_range(1, 70)) : int'($urandom_range(1, 8));
            for (int c = 0; c < len; c++)
                step(bp, bm, ($urandom_range(0, 3) != 0), "random");
        end

        // Reset in the middle of a hold discards the partial count.
        for (int c = 0; c < 5; c++) step(0, 0, 1, "pre_rst");
        for (int c = 0; c < 30; c++) step(1, 0, 1, "rst_hold");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < int'(PRESS) - 1; c++) step(1, 0, 1, "post_rst_hold");
        check("post_rst_49", 0, 0, 0, 0);
        step(1, 0, 1, "post_rst_50");
        check("post_rst_on", 1, 0, 2, 1);
        step(0, 0, 1, "post_rst_rel");
        check("post_rst_rel", 1, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/power_mode_ctrl.md
POWER_MODE_CTRL -- requirements
Module: power_mode_ctrl

Interface
REQ-001 The block SHALL have parameter PRESS_CYCLES, default 50, consecutive high cycles on btn_power that constitute a long press.
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, consecutive high cycles on btn_mode that constitute a valid mode press.
REQ-003 The block SHALL have parameter IDLE_CYCLES, default 32'd100_000_000, cycles without activity before auto power-off.
REQ-004 The block SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port btn_power, input, 1, synchronised power button level, high = pressed.
REQ-007 The block SHALL have port btn_mode, input, 1, synchronised mode button level, high = pressed.
REQ-008 The block SHALL have port activity, input, 1, high in any cycle with drive or steering command.
REQ-009 The block SHALL have port power_on, output, 1, registered power enable to the motor and datapath.
REQ-010 The block SHALL have port mode, output, 2, registered drive mode: 0 manual, 1 semi-auto, 2 auto; 3 never driven.
REQ-011 The block SHALL have port state, output, 2, registered FSM state code.
REQ-012 The block SHALL have port pwr_evt, output, 1, one-cycle pulse on every power_on change.

Function
REQ-013 The FSM SHALL have states OFF=0, ON=1, REL_WAIT=2; code 3 SHALL return to OFF on the next edge.
REQ-014 A press counter SHALL increment each cycle btn_power=1, clear when btn_power=0, and saturate at PRESS_CYCLES.
REQ-015 A long press SHALL be the edge at which the counter goes from PRESS_CYCLES-1 to PRESS_CYCLES, giving a single one-cycle strobe per hold.
REQ-016 In OFF, a long press SHALL set power_on=1, mode=0, and state=REL_WAIT at that same edge.
REQ-017 In ON, a long press SHALL set power_on=0 and state=REL_WAIT at that same edge.
REQ-018 REL_WAIT SHALL ignore both buttons and move to ON if power_on=1, else to OFF, on the first edge with btn_power=0.
REQ-019 Holding btn_power indefinitely SHALL produce exactly one power transition.
REQ-020 In ON only, a btn_mode debounce counter reaching DEB_CYCLES SHALL advance mode 0->1->2->0 exactly once per press.
REQ-021 btn_mode SHALL be re-armed only after btn_mode=0 for at least one cycle.
REQ-022 btn_mode SHALL be ignored in OFF and REL_WAIT, and mode SHALL hold its value while OFF.
REQ-023 If a power long press and a mode event fall on the same edge, the power transition SHALL win and the mode event SHALL be discarded.
REQ-024 pwr_evt SHALL be 1 for exactly the cycle after each power_on change, and 0 otherwise.

Reset
REQ-025 When rst_n=0, regardless of clk, the block SHALL force power_on=0, mode=0, state=OFF, pwr_evt=0, and clear all counters and arm flags.
REQ-026 Reset asserted mid-press SHALL discard the partial count, and a press held through reset release SHALL count from 0.

Configuration
REQ-027 With macro POWER_IDLE_TIMEOUT_EN defined, an idle counter SHALL clear on activity=1 or any button high, increment otherwise in ON, and force the ON-to-OFF transition with pwr_evt on reaching IDLE_CYCLES.
REQ-028 When the idle timeout fires, the FSM SHALL enter OFF directly, not REL_WAIT.
REQ-029 Without POWER_IDLE_TIMEOUT_EN, the idle counter SHALL not be synthesised, IDLE_CYCLES SHALL be unused, and power-off SHALL occur only by long press.

Structure
REQ-030 Package power_ctrl_pkg SHALL hold the state encoding (OFF/ON/REL_WAIT), mode encoding (MANUAL/SEMI/AUTO), and default PRESS_CYCLES/DEB_CYCLES/IDLE_CYCLES constants.
REQ-031 The block SHALL instantiate sub-module hold_detector (parameter N, inputs clk/rst_n/level, output one-cycle strobe on the Nth consecutive high cycle, re-armed by low) twice: once for btn_power with N=PRESS_CYCLES, once for btn_mode with N=DEB_CYCLES.

Verification
REQ-032 Bench parameters SHALL be PRESS=50, DEB=4, IDLE=1000.
REQ-033 Holding btn_power high 49 cycles then releasing SHALL leave power_on=0 and pwr_evt=0.
REQ-034 Holding btn_power 50 cycles SHALL give power_on=1 at the 50th edge, state=REL_WAIT, and one pwr_evt; holding 500 cycles SHALL produce no further change; release SHALL give state=ON.
REQ-035 In ON, four btn_mode presses of 6 cycles each separated by 3 low cycles SHALL give mode sequence 1,2,0,1; a 3-cycle press SHALL leave mode unchanged.
REQ-036 In ON, a btn_power hold of 50 cycles SHALL give power_on=0; the following btn_mode presses SHALL be ignored; a subsequent power-on SHALL give mode=0.
REQ-037 With POWER_IDLE_TIMEOUT_EN, ON with activity=0 for 1000 cycles SHALL give power_on=0, state=OFF, and one pwr_evt; an activity pulse at cycle 999 SHALL restart the count.
REQ-038 rst_n asserted at count 30 of a held btn_power SHALL force all outputs to 0 immediately, and after release 50 further held cycles SHALL be needed for power-on.
